sync_det: RTL and testbench

//  Receive side of the 1280x720 raster timing (vsync/hsync/de, active-high).

---
 rtl/sync_det_pkg.sv | 31 +++
 rtl/sync_edge.sv | 37 +++
 rtl/sync_det.sv | 242 ++++++++++++++++++++++++
 tb/tb_sync_det.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_det_pkg.sv
// sync_det_pkg
//   Shared types and constants for the raster timing detector.
//   - sync_det_state_t : lock FSM states (IDLE, CHECK, LOCKED)
//   - DEF_*            : default 1280x720 geometry and counter widths
//   - cnt_bits()       : bits needed to hold the values 0..max_val
package sync_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } sync_det_state_t;

  localparam int unsigned DEF_H_ACT       = 1280;
  localparam int unsigned DEF_V_ACT       = 720;
  localparam int unsigned DEF_X_BITS      = 11;
  localparam int unsigned DEF_Y_BITS      = 10;
  localparam int unsigned DEF_LOCK_FRAMES = 2;
  localparam int unsigned DEF_TO_BITS     = 22;

  // Minimum width (at least 1) that can represent max_val.
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    int unsigned b;
    b = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) b = i + 1;
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Two-stage register for one sync/enable input plus rise/fall strobes.
//   The strobes compare stage 1 against stage 2, so they are valid in the
//   same cycle that stage 2 is about to take the new level; logic clocked
//   on that edge lines up with q.
// Ports:
//   clk  in   pixel clock
//   rst  in   asynchronous reset, active-high
//   d    in   raw input
//   q    out  d delayed 2 clk
//   rise out  d has risen (q goes high on the next edge)
//   fall out  d has fallen (q goes low on the next edge)
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

  assign rise = s1 & ~q;
  assign fall = ~s1 & q;

endmodule

// File: rtl/sync_det.sv
// sync_det
//   Receive-side raster timing detector. Recovers active x/y and a
//   frame_start marker from vsync/hsync/de, measures the active size and
//   raises locked after LOCK_FRAMES consecutive frames of H_ACT x V_ACT.
//   A vsync watchdog drops lock when vsync stops arriving.
//   All outputs lag the inputs by exactly 2 clk.
// Configuration macro:
//   SYNC_DET_TOTALS_EN - adds meas_h_total / meas_v_total (line and frame
//   totals measured from hsync).
// Ports:
//   clk, rst                     pixel clock, async active-high reset
//   vsync_in, hsync_in, de_in    raw timing inputs
//   vsync_out, hsync_out, de_out inputs delayed 2 clk (de_out qualifies x/y)
//   x, y                         active pixel / line index
//   frame_start                  pulse on first de cycle of a frame
//   locked                       geometry matches H_ACT x V_ACT
//   frame_err                    pulse when a judged frame mismatches
//   meas_h_act, meas_v_act       last line de length / last frame line count
//   meas_h_total, meas_v_total   (SYNC_DET_TOTALS_EN only) clk per line,
//                                lines per frame
module sync_det
  import sync_det_pkg::*;
#(
  parameter int unsigned H_ACT       = DEF_H_ACT,
  parameter int unsigned V_ACT       = DEF_V_ACT,
  parameter int unsigned X_BITS      = DEF_X_BITS,
  parameter int unsigned Y_BITS      = DEF_Y_BITS,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES,
  parameter int unsigned TO_BITS     = DEF_TO_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync_in,
  input  logic              hsync_in,
  input  logic              de_in,
  output logic              vsync_out,
  output logic              hsync_out,
  output logic              de_out,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              frame_start,
  output logic              locked,
  output logic              frame_err,
  output logic [X_BITS-1:0] meas_h_act,
`ifdef SYNC_DET_TOTALS_EN
  output logic [Y_BITS-1:0] meas_v_act,
  output logic [X_BITS-1:0] meas_h_total,
  output logic [Y_BITS-1:0] meas_v_total
`else
  output logic [Y_BITS-1:0] meas_v_act
`endif
);

  localparam int unsigned CNT_BITS = cnt_bits(LOCK_FRAMES);
  localparam logic [X_BITS-1:0]   X_ONE   = X_BITS'(1);
  localparam logic [Y_BITS-1:0]   Y_ONE   = Y_BITS'(1);
  localparam logic [TO_BITS-1:0]  WD_ONE  = TO_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  // ---------------------------------------------------------------- edges
  logic vs_rise, vs_fall, hs_rise, hs_fall, de_rise, de_fall;

  sync_edge u_vs (.clk(clk), .rst(rst), .d(vsync_in), .q(vsync_out), .rise(vs_rise), .fall(vs_fall));
  sync_edge u_hs (.clk(clk), .rst(rst), .d(hsync_in), .q(hsync_out), .rise(hs_rise), .fall(hs_fall));
  sync_edge u_de (.clk(clk), .rst(rst), .d(de_in),    .q(de_out),    .rise(de_rise), .fall(de_fall));

  // ------------------------------------------------------ x/y, measurement
  logic [X_BITS-1:0] line0_len;
  logic [X_BITS-1:0] h_len;
  logic [Y_BITS-1:0] y_inc;
  logic              line_bad;
  logic              line_mis;
  logic              fs_armed;
  logic [X_BITS-1:0] h_eff;
  logic [Y_BITS-1:0] v_eff;
  logic              frame_match;

  // x holds the index of the last de cycle, so the line length is x + 1.
  assign h_len    = (x == '1) ? x : x + X_ONE;
  assign y_inc    = (y == '1) ? y : y + Y_ONE;
  assign line_mis = de_fall && (y != '0) && (h_len != line0_len);

  // A de fall coinciding with a vsync rise belongs to the frame being
  // closed, so the judged values include that line.
  assign h_eff       = de_fall ? h_len : meas_h_act;
  assign v_eff       = de_fall ? y_inc : y;
  assign frame_match = (h_eff == X_BITS'(H_ACT)) && (v_eff == Y_BITS'(V_ACT))
                       && !(line_bad || line_mis);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      line0_len   <= '0;
      line_bad    <= 1'b0;
      meas_h_act  <= '0;
      meas_v_act  <= '0;
      fs_armed    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      if (de_rise) begin
        x <= '0;
      end else if (de_out && !de_fall && (x != '1)) begin
        x <= x + X_ONE;
      end

      if (de_fall) begin
        meas_h_act <= h_len;
        if (y == '0) line0_len <= h_len;
      end

      if (vs_rise) begin
        meas_v_act <= v_eff;
        y          <= '0;
        line_bad   <= 1'b0;
        fs_armed   <= 1'b1;
      end else begin
        if (de_fall)  y        <= y_inc;
        if (line_mis) line_bad <= 1'b1;
      end

      if (de_rise && (fs_armed || vs_rise)) begin
        frame_start <= 1'b1;
        fs_armed    <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- watchdog
  logic [TO_BITS-1:0] wd;
  logic [TO_BITS-1:0] wd_n;
  logic               wd_timeout;

  assign wd_n       = vs_rise ? '0 : ((wd == '1) ? wd : wd + WD_ONE);
  assign wd_timeout = !vs_rise && (wd_n == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd <= '0;
    else     wd <= wd_n;
  end

  // -------------------------------------------------------------- lock FSM
  sync_det_state_t     state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  logic                err_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
    if (wd_timeout) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (vs_rise) begin
      unique case (state)
        IDLE: begin
          state_n = CHECK;
          cnt_n   = '0;
        end
        CHECK: begin
          if (frame_match) begin
            cnt_n = cnt + CNT_ONE;
            if (cnt_n == CNT_BITS'(LOCK_FRAMES)) state_n = LOCKED;
          end else begin
            cnt_n = '0;
            err_n = 1'b1;
          end
        end
        LOCKED: begin
          if (!frame_match) begin
            state_n = CHECK;
            cnt_n   = '0;
            err_n   = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      locked    <= (state_n == LOCKED);
      frame_err <= err_n;
    end
  end

  // ----------------------------------------------------------------- totals
`ifdef SYNC_DET_TOTALS_EN
  logic [X_BITS-1:0] h_tot_cnt;
  logic [Y_BITS-1:0] v_tot_cnt;
  logic [X_BITS-1:0] h_tot_inc;
  logic [Y_BITS-1:0] v_tot_inc;

  assign h_tot_inc = (h_tot_cnt == '1) ? h_tot_cnt : h_tot_cnt + X_ONE;
  assign v_tot_inc = (v_tot_cnt == '1) ? v_tot_cnt : v_tot_cnt + Y_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_tot_cnt    <= '0;
      v_tot_cnt    <= '0;
      meas_h_total <= '0;
      meas_v_total <= '0;
    end else begin
      // h_tot_cnt counts edges since the last hsync rise; +1 covers this clk.
      if (hs_rise) begin
        meas_h_total <= h_tot_inc;
        h_tot_cnt    <= '0;
      end else begin
        h_tot_cnt <= h_tot_inc;
      end

      // An hsync rise on the vsync rise cycle closes the ending frame.
      if (vs_rise) begin
        meas_v_total <= hs_rise ? v_tot_inc : v_tot_cnt;
        v_tot_cnt    <= '0;
      end else if (hs_rise) begin
        v_tot_cnt <= v_tot_inc;
      end
    end
  end

  logic unused_edges;
  assign unused_edges = &{1'b0, vs_fall, hs_fall};
`else
  logic unused_edges;
  assign unused_edges = &{1'b0, vs_fall, hs_fall, hs_rise};
`endif

endmodule

// File: tb/tb_sync_det.sv
// tb_sync_det
//   Directed bench for sync_det with a 16x4 active raster inside a 24x7
//   total raster. Each driven cycle carries its expected outputs, compared
//   two clocks later; per-frame measurement checks and reset checks are
//   added on top. Define SYNC_DET_TOTALS_EN to also check the totals.
module tb_sync_det;

  localparam int unsigned H_ACT       = 16;
  localparam int unsigned V_ACT       = 4;
  localparam int unsigned X_BITS      = 11;
  localparam int unsigned Y_BITS      = 10;
  localparam int unsigned LOCK_FRAMES = 2;
  localparam int unsigned TO_BITS     = 10;
  localparam int          H_TOTAL     = 24;
  localparam int          V_TOTAL     = 7;
  localparam int          WD_LIMIT    = 1023;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              vsync_in = 1'b0;
  logic              hsync_in = 1'b0;
  logic              de_in = 1'b0;
  logic              vsync_out, hsync_out, de_out;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic              frame_start, locked, frame_err;
  logic [X_BITS-1:0] meas_h_act;
  logic [Y_BITS-1:0] meas_v_act;
`ifdef SYNC_DET_TOTALS_EN
  logic [X_BITS-1:0] meas_h_total;
  logic [Y_BITS-1:0] meas_v_total;
`endif

  sync_det #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
    .LOCK_FRAMES(LOCK_FRAMES), .TO_BITS(TO_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .de_out(de_out),
    .x(x), .y(y), .frame_start(frame_start), .locked(locked),
    .frame_err(frame_err), .meas_h_act(meas_h_act),
`ifdef SYNC_DET_TOTALS_EN
    .meas_v_act(meas_v_act), .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
`else
    .meas_v_act(meas_v_act)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vs, hs, de, fs, err, lk;
    int   x, y;
  } exp_t;

  exp_t p1, p2;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic lk_frame = 1'b0;
  logic armed = 1'b0;
  int   since_vs = 0;
  int   frames_since_rst = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle(input exp_t e);
    check("vsync_out", vsync_out, e.vs);
    check("hsync_out", hsync_out, e.hs);
    check("de_out", de_out, e.de);
    check("frame_start", frame_start, e.fs);
    check("frame_err", frame_err, e.err);
    check("locked", locked, e.lk);
    if (e.de) begin
      check("x", x, e.x);
      check("y", y, e.y);
    end
  endtask

  // One pixel clock: check the cycle driven two clocks ago, then drive.
  task automatic step(input logic vs, input logic hs, input logic de,
                      input int px, input int ln, input logic new_frame,
                      input logic err);
    exp_t cur;
    @(negedge clk);
    check_cycle(p2);
    if (new_frame) begin
      since_vs = 0;
      armed    = 1'b1;
    end else if (since_vs < 1000000) begin
      since_vs++;
    end
    cur.vs  = vs;
    cur.hs  = hs;
    cur.de  = de;
    cur.x   = px;
    cur.y   = ln;
    cur.fs  = de && (px == 0) && armed;
    if (cur.fs) armed = 1'b0;
    cur.err = err;
    cur.lk  = lk_frame && (since_vs < WD_LIMIT);
    vsync_in = vs;
    hsync_in = hs;
    de_in    = de;
    p2 = p1;
    p1 = cur;
  endtask

  // Frame: line 0 carries vsync, lines 1..n_act are active (de at clk 4..),
  // remaining lines blank. exp_lk/exp_err describe this frame's vsync rise.
  task automatic drive_frame(input int n_act, input int bad_line, input int bad_len,
                             input logic exp_lk, input logic exp_err,
                             input int exp_v, input int abort_at);
    int   c;
    int   len;
    int   last_len;
    logic de;
    c = 0;
    lk_frame = exp_lk;
    frames_since_rst++;
    for (int l = 0; l < V_TOTAL; l++) begin
      for (int k = 0; k < H_TOTAL; k++) begin
        if (abort_at != 0 && c == abort_at) return;
        len = ((l - 1) == bad_line) ? bad_len : H_ACT;
        de  = (l >= 1) && (l <= n_act) && (k >= 4) && (k < 4 + len);
        step(l == 0, k < 2, de, k - 4, l - 1, (l == 0) && (k == 0),
             ((l == 0) && (k == 0)) ? exp_err : 1'b0);
        c++;
      end
    end
    last_len = ((n_act - 1) == bad_line) ? bad_len : H_ACT;
    check("meas_h_act", meas_h_act, last_len);
    check("meas_v_act", meas_v_act, exp_v);
`ifdef SYNC_DET_TOTALS_EN
    if (frames_since_rst >= 2) begin
      check("meas_h_total", meas_h_total, H_TOTAL);
      check("meas_v_total", meas_v_total, V_TOTAL);
    end
`endif
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vsync_out", vsync_out, 0);
    check("rst_hsync_out", hsync_out, 0);
    check("rst_de_out", de_out, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_locked", locked, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_meas_h_act", meas_h_act, 0);
    check("rst_meas_v_act", meas_v_act, 0);
`ifdef SYNC_DET_TOTALS_EN
    check("rst_meas_h_total", meas_h_total, 0);
    check("rst_meas_v_total", meas_v_total, 0);
`endif
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    de_in    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    p1 = '{default: 0};
    p2 = '{default: 0};
    lk_frame = 1'b0;
    armed = 1'b0;
    since_vs = 0;
    frames_since_rst = 0;
  endtask

  initial begin
    p1 = '{default: 0};
    p2 = '{default: 0};
    do_reset();

    // Ideal raster: lock on the 3rd vsync rise.
    drive_frame(4, -1, 0, 1'b0, 1'b0, 0, 0);
    drive_frame(4, -1, 0, 1'b0, 1'b0, 4, 0);
    drive_frame(4, -1, 0, 1'b1, 1'b0, 4, 0);
    drive_frame(4, -1, 0, 1'b1, 1'b0, 4, 0);

    // One short middle line breaks lock, two good frames relock.
    drive_frame(4, 1, 15, 1'b1, 1'b0, 4, 0);
    drive_frame(4, -1, 0, 1'b0, 1'b1, 4, 0);
    drive_frame(4, -1, 0, 1'b0, 1'b0, 4, 0);
    drive_frame(4, -1, 0, 1'b1, 1'b0, 4, 0);

    // Five active lines: error every judged frame, never locked.
    do_reset();
    drive_frame(5, -1, 0, 1'b0, 1'b0, 0, 0);
    drive_frame(5, -1, 0, 1'b0, 1'b1, 5, 0);
    drive_frame(5, -1, 0, 1'b0, 1'b1, 5, 0);
    drive_frame(5, -1, 0, 1'b0, 1'b1, 5, 0);

    // Lock, then stop vsync: watchdog drops lock without frame_err.
    drive_frame(4, -1, 0, 1'b0, 1'b1, 5, 0);
    drive_frame(4, -1, 0, 1'b0, 1'b0, 4, 0);
    drive_frame(4, -1, 0, 1'b1, 1'b0, 4, 0);
    drive_idle(1100);
    check("wd_locked", locked, 0);
    drive_frame(4, -1, 0, 1'b0, 1'b0, 4, 0);
    drive_frame(4, -1, 0, 1'b0, 1'b0, 4, 0);
    drive_frame(4, -1, 0, 1'b1, 1'b0, 4, 0);

    // Reset in the middle of an active line, then relock from scratch.
    drive_frame(4, -1, 0, 1'b1, 1'b0, 4, 58);
    do_reset();
    drive_frame(4, -1, 0, 1'b0, 1'b0, 0, 0);
    drive_frame(4, -1, 0, 1'b0, 1'b0, 4, 0);
    drive_frame(4, -1, 0, 1'b1, 1'b0, 4, 0);
    drive_idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
